imm_extend_q: RTL and testbench

Parametrised, buffered immediate-formation stage for the decode/execute path. It accepts an immediate field plus a mode code through a valid/ready handshake and computes the DATA_W-wide operand: sign, zero, upper-load, shift-amount, branch-offset or jump-index form. Results pass through a DEPTH-entry in-order queue, together with a caller tag, so decode can run ahead of a stalled consumer. Illegal modes are flagged, and they are also counted in a saturating counter.

---
 rtl/imm_extend_q_if.sv | 38 +++
 rtl/imm_extend_q.sv | 162 ++++++++++++++++
 tb/tb_imm_extend_q.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_extend_q_if.sv
// Handshake bundle for the immediate-formation stage: request side, result side, error status.
// Pure wiring, no latency of its own.
// Backpressure is carried by in_ready (stage to producer) and out_ready (consumer to stage).
interface imm_extend_q_if #(
    parameter int IMM_W    = 16,
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 5,
    parameter int ERRCNT_W = 8
);
    // request side
    logic                in_valid;
    logic                in_ready;
    logic [IMM_W-1:0]    in_imm;
    logic [2:0]          in_mode;
    logic [TAG_W-1:0]    in_tag;

    // result side
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out_imm;
    logic [TAG_W-1:0]    out_tag;
    logic                out_err;

    // status
    logic [ERRCNT_W-1:0] err_count;

    // producer/consumer view (drives requests, takes results)
    modport master (
        output in_valid, in_imm, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_err, err_count
    );

    // stage view
    modport slave (
        input  in_valid, in_imm, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_err, err_count
    );
endinterface

// File: rtl/imm_extend_q.sv
// Forms a DATA_W operand from an immediate + mode and queues it (with tag/err) in a DEPTH-entry FIFO.
// Latency 1 cycle from accept to out_valid when empty; one accept and one pop per cycle.
// in_ready = queue not full, from registered count only (no path from out_ready); outputs hold while stalled.
module imm_extend_q #(
    parameter int IMM_W    = 16,
    parameter int DATA_W   = 32,
    parameter int SHAMT_W  = 5,
    parameter int TAG_W    = 5,
    parameter int DEPTH    = 2,
    parameter int ERRCNT_W = 8
) (
    input  logic          CLK,
    input  logic          nRST,
    imm_extend_q_if.slave bus
);

    // Pointer width is kept at least 1 so DEPTH=1 still has a legal vector.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int EXT_W = DATA_W - IMM_W;

    localparam logic [2:0] MODE_SIGN   = 3'd0;
    localparam logic [2:0] MODE_ZERO   = 3'd1;
    localparam logic [2:0] MODE_LUI    = 3'd2;
    localparam logic [2:0] MODE_SHAMT  = 3'd3;
    localparam logic [2:0] MODE_BRANCH = 3'd4;
    localparam logic [2:0] MODE_JINDEX = 3'd5;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // Queue bookkeeping
    logic [PTR_W-1:0]    head_q, head_d;
    logic [PTR_W-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ERRCNT_W-1:0] err_count_q, err_count_d;

    // Entry storage; contents are only observed when count says the slot is live.
    logic [DATA_W-1:0]   mem_imm_q [DEPTH];
    logic [TAG_W-1:0]    mem_tag_q [DEPTH];
    logic                mem_err_q [DEPTH];

    // Formation results for the request currently offered
    logic [DATA_W-1:0]   sign_ext;
    logic [DATA_W-1:0]   zero_ext;
    logic [DATA_W-1:0]   form_imm;
    logic                form_err;

    // Handshake qualifiers
    logic                in_ready_w;
    logic                out_valid_w;
    logic                acc;
    logic                pop;

    // Circular increment that wraps at DEPTH-1, so non-power-of-2 depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == PTR_LAST) begin
            r = '0;
        end else begin
            r = p + PTR_W'(1);
        end
        return r;
    endfunction

    // Form the operand for the offered immediate; illegal modes give zero and raise err.
    always_comb begin
        sign_ext = {{EXT_W{bus.in_imm[IMM_W-1]}}, bus.in_imm};
        zero_ext = {{EXT_W{1'b0}}, bus.in_imm};
        form_imm = '0;
        form_err = 1'b0;
        case (bus.in_mode)
            MODE_SIGN:   form_imm = sign_ext;
            MODE_ZERO:   form_imm = zero_ext;
            // immediate lands in the top IMM_W bits, zeros fill below
            MODE_LUI:    form_imm = zero_ext << EXT_W;
            // only the low SHAMT_W bits carry a shift amount
            MODE_SHAMT:  form_imm = {{(DATA_W - SHAMT_W){1'b0}}, bus.in_imm[SHAMT_W-1:0]};
            // word-aligned offsets: bits shifted out of the top are dropped
            MODE_BRANCH: form_imm = sign_ext << 2;
            MODE_JINDEX: form_imm = zero_ext << 2;
            default: begin
                form_imm = '0;
                form_err = 1'b1;
            end
        endcase
    end

    // Handshake decisions come from registered count only.
    always_comb begin
        in_ready_w  = (count_q < CNT_FULL);
        out_valid_w = (count_q != '0);
        acc         = bus.in_valid && in_ready_w;
        pop         = out_valid_w && bus.out_ready;
    end

    // Next-state for pointers, occupancy and the saturating illegal-mode counter.
    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        err_count_d = err_count_q;

        if (acc) begin
            tail_d = ptr_inc(tail_q);
        end
        if (pop) begin
            head_d = ptr_inc(head_q);
        end

        // simultaneous accept and pop leaves the occupancy unchanged
        case ({acc, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (acc && form_err && (err_count_q != '1)) begin
            err_count_d = err_count_q + ERRCNT_W'(1);
        end
    end

    // Control state with synchronous active-low reset; reset drops every queued entry.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            err_count_q <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            err_count_q <= err_count_d;
        end
    end

    // Write the formed entry at the tail; storage is left unreset since count gates it.
    always_ff @(posedge CLK) begin
        if (acc) begin
            mem_imm_q[tail_q] <= form_imm;
            mem_tag_q[tail_q] <= bus.in_tag;
            mem_err_q[tail_q] <= form_err;
        end
    end

    // Head entry is presented only while the queue is non-empty; otherwise all zero.
    always_comb begin
        bus.in_ready  = in_ready_w;
        bus.out_valid = out_valid_w;
        bus.err_count = err_count_q;
        bus.out_imm   = '0;
        bus.out_tag   = '0;
        bus.out_err   = 1'b0;
        if (out_valid_w) begin
            bus.out_imm = mem_imm_q[head_q];
            bus.out_tag = mem_tag_q[head_q];
            bus.out_err = mem_err_q[head_q];
        end
    end

endmodule

// File: tb/tb_imm_extend_q.sv
// Bench for imm_extend_q: two instances (DEPTH=2/ERRCNT_W=8 and DEPTH=3/ERRCNT_W=2) share stimulus.
// Each is compared every cycle against a queue-based reference model, plus directed constant checks.
// Stimulus covers all modes, illegal saturation, backpressure, streaming wrap, random stalls and reset.
module tb_imm_extend_q;

    typedef struct packed {
        logic [31:0] imm;
        logic [4:0]  tag;
        logic        err;
    } ent_t;

    localparam int DEP  [2] = '{2, 3};
    localparam int MAXE [2] = '{255, 3};
    localparam logic [31:0] MODE_EXP [6] = '{32'hFFFF8001, 32'h00008001, 32'h80010000,
                                             32'h00000001, 32'hFFFE0004, 32'h00020004};

    logic        CLK = 1'b0;
    logic        nRST;
    logic        in_valid;
    logic [15:0] in_imm;
    logic [2:0]  in_mode;
    logic [4:0]  in_tag;
    logic        out_ready;

    logic        o_vld [2];
    logic        o_rdy [2];
    logic [31:0] o_imm [2];
    logic [4:0]  o_tag [2];
    logic        o_err [2];
    logic [7:0]  o_ec  [2];

    int n_assert = 0;
    int n_fail   = 0;
    int dut_pops [2] = '{0, 0};

    ent_t mq  [2][$];
    int   mec [2] = '{0, 0};

    always #5 CLK = ~CLK;

    imm_extend_q_if #(.IMM_W(16), .DATA_W(32), .TAG_W(5), .ERRCNT_W(8)) bus_a ();
    imm_extend_q_if #(.IMM_W(16), .DATA_W(32), .TAG_W(5), .ERRCNT_W(2)) bus_b ();

    imm_extend_q #(.IMM_W(16), .DATA_W(32), .SHAMT_W(5), .TAG_W(5), .DEPTH(2), .ERRCNT_W(8))
        u_dut_a (.CLK(CLK), .nRST(nRST), .bus(bus_a));
    imm_extend_q #(.IMM_W(16), .DATA_W(32), .SHAMT_W(5), .TAG_W(5), .DEPTH(3), .ERRCNT_W(2))
        u_dut_b (.CLK(CLK), .nRST(nRST), .bus(bus_b));

    assign bus_a.in_valid  = in_valid;
    assign bus_a.in_imm    = in_imm;
    assign bus_a.in_mode   = in_mode;
    assign bus_a.in_tag    = in_tag;
    assign bus_a.out_ready = out_ready;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.in_imm    = in_imm;
    assign bus_b.in_mode   = in_mode;
    assign bus_b.in_tag    = in_tag;
    assign bus_b.out_ready = out_ready;

    assign o_vld[0] = bus_a.out_valid;
    assign o_rdy[0] = bus_a.in_ready;
    assign o_imm[0] = bus_a.out_imm;
    assign o_tag[0] = bus_a.out_tag;
    assign o_err[0] = bus_a.out_err;
    assign o_ec[0]  = bus_a.err_count;
    assign o_vld[1] = bus_b.out_valid;
    assign o_rdy[1] = bus_b.in_ready;
    assign o_imm[1] = bus_b.out_imm;
    assign o_tag[1] = bus_b.out_tag;
    assign o_err[1] = bus_b.out_err;
    assign o_ec[1]  = 8'(bus_b.err_count);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference formation from the mode rules using integer arithmetic, truncated to 32 bits.
    function automatic ent_t ref_form(input logic [15:0] imm, input logic [2:0] mode,
                                      input logic [4:0] tag);
        longint zv;
        longint sv;
        longint r;
        ent_t   e;
        zv    = longint'(imm);
        sv    = (imm >= 16'h8000) ? zv - 65536 : zv;
        e.tag = tag;
        e.err = 1'b0;
        case (mode)
            3'd0: r = sv;
            3'd1: r = zv;
            3'd2: r = zv * 65536;
            3'd3: r = zv % 32;
            3'd4: r = sv * 4;
            3'd5: r = zv * 4;
            default: begin
                r     = 0;
                e.err = 1'b1;
            end
        endcase
        e.imm = 32'(r);
        return e;
    endfunction

    // Advance the reference queues by one clock edge using the inputs seen at that edge.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (!nRST) begin
                mq[i].delete();
                mec[i] = 0;
            end else begin
                int   sz;
                bit   pop;
                bit   acc;
                ent_t e;
                sz  = mq[i].size();
                pop = (sz > 0) && out_ready;
                acc = in_valid && (sz < DEP[i]);
                if (pop) void'(mq[i].pop_front());
                if (acc) begin
                    e = ref_form(in_imm, in_mode, in_tag);
                    mq[i].push_back(e);
                    if (e.err && mec[i] < MAXE[i]) mec[i]++;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            int   sz;
            ent_t h;
            sz = mq[i].size();
            h  = '0;
            if (sz > 0) h = mq[i][0];
            check($sformatf("u%0d_out_valid", i), 64'(o_vld[i]), 64'(sz > 0));
            check($sformatf("u%0d_in_ready", i),  64'(o_rdy[i]), 64'(sz < DEP[i]));
            check($sformatf("u%0d_out_imm", i),   64'(o_imm[i]), 64'(h.imm));
            check($sformatf("u%0d_out_tag", i),   64'(o_tag[i]), 64'(h.tag));
            check($sformatf("u%0d_out_err", i),   64'(o_err[i]), 64'(h.err));
            check($sformatf("u%0d_err_count", i), 64'(o_ec[i]),  64'(mec[i]));
        end
    endtask

    // One clock: count DUT pops, step the model at the edge, compare on the falling edge.
    task automatic tick();
        for (int i = 0; i < 2; i++) begin
            if (o_vld[i] && out_ready) dut_pops[i]++;
        end
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        check_all();
    endtask

    task automatic drive(input logic v, input logic [15:0] imm, input logic [2:0] mode,
                         input logic [4:0] tag);
        in_valid = v;
        in_imm   = imm;
        in_mode  = mode;
        in_tag   = tag;
    endtask

    task automatic drain();
        drive(1'b0, 16'h0, 3'd0, 5'd0);
        out_ready = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        int nreq;
        int cyc;
        int pops0;
        bit took;

        nRST = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 16'h0, 3'd0, 5'd0);
        repeat (3) tick();
        nRST = 1'b1;
        tick();
        check("reset_in_ready", 64'(o_rdy[0]), 64'd1);
        check("reset_out_valid", 64'(o_vld[1]), 64'd0);

        // every legal mode on 0x8001, consumed immediately
        out_ready = 1'b1;
        for (int m = 0; m < 6; m++) begin
            drive(1'b1, 16'h8001, 3'(m), 5'(m + 10));
            tick();
            check($sformatf("mode%0d_imm", m), 64'(o_imm[0]), 64'(MODE_EXP[m]));
            check($sformatf("mode%0d_err", m), 64'(o_err[0]), 64'd0);
            check($sformatf("mode%0d_tag", m), 64'(o_tag[0]), 64'(m + 10));
        end
        drain();

        // illegal modes and counter saturation
        drive(1'b1, 16'h1234, 3'd6, 5'd7);
        tick();
        check("illegal_imm", 64'(o_imm[0]), 64'd0);
        check("illegal_err", 64'(o_err[0]), 64'd1);
        check("illegal_tag", 64'(o_tag[0]), 64'd7);
        check("illegal_cnt", 64'(o_ec[0]), 64'd1);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 16'(k), 3'(6 + (k % 2)), 5'(k));
            tick();
        end
        drain();
        check("errcnt_w8", 64'(o_ec[0]), 64'd5);
        check("errcnt_sat_w2", 64'(o_ec[1]), 64'd3);

        // backpressure with the consumer stalled
        out_ready = 1'b0;
        drive(1'b1, 16'h0011, 3'd1, 5'd1);
        tick();
        drive(1'b1, 16'h0022, 3'd1, 5'd2);
        tick();
        check("bp_full_rdy", 64'(o_rdy[0]), 64'd0);
        drive(1'b1, 16'h0033, 3'd1, 5'd3);
        tick();
        check("bp_still_full", 64'(o_rdy[0]), 64'd0);
        check("bp_head_held", 64'(o_tag[0]), 64'd1);
        drive(1'b0, 16'h0, 3'd0, 5'd0);
        out_ready = 1'b1;
        tick();
        check("bp_pop2_tag", 64'(o_tag[0]), 64'd2);
        check("bp_rdy_after_pop", 64'(o_rdy[0]), 64'd1);
        tick();
        check("bp_third_dropped", 64'(o_vld[0]), 64'd0);
        drain();

        // back-to-back streaming across pointer wrap
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 16'($urandom), 3'($urandom_range(0, 5)), 5'(k));
            tick();
            check("stream_vld", 64'(o_vld[1]), 64'd1);
            check("stream_tag", 64'(o_tag[1]), 64'(k));
            check("stream_occ_le1", 64'(o_rdy[0]), 64'd1);
        end
        drain();

        // random requests against random consumer stalls
        pops0 = dut_pops[0];
        nreq  = 0;
        cyc   = 0;
        in_valid = 1'b0;
        while (nreq < 200 && cyc < 3000) begin
            if (!in_valid && ($urandom % 4 != 0)) begin
                drive(1'b1, 16'($urandom), 3'($urandom_range(0, 7)), 5'($urandom));
            end
            out_ready = 1'($urandom % 2);
            took = in_valid && (mq[0].size() < DEP[0]);
            tick();
            cyc++;
            if (took) begin
                nreq++;
                in_valid = 1'b0;
            end
        end
        drain();
        check("rand_pops", 64'(dut_pops[0] - pops0), 64'd200);

        // reset with entries queued
        out_ready = 1'b0;
        drive(1'b1, 16'h0005, 3'd7, 5'd4);
        tick();
        drive(1'b1, 16'h0006, 3'd7, 5'd5);
        tick();
        check("pre_rst_vld", 64'(o_vld[0]), 64'd1);
        nRST = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 16'h0009, 3'd0, 5'd9);
        tick();
        nRST = 1'b1;
        drive(1'b0, 16'h0, 3'd0, 5'd0);
        check("rst_vld", 64'(o_vld[0]), 64'd0);
        check("rst_errcnt", 64'(o_ec[0]), 64'd0);
        check("rst_rdy", 64'(o_rdy[1]), 64'd1);
        drive(1'b1, 16'h00FF, 3'd1, 5'd21);
        tick();
        check("post_rst_vld", 64'(o_vld[0]), 64'd1);
        check("post_rst_tag", 64'(o_tag[0]), 64'd21);
        check("post_rst_imm", 64'(o_imm[0]), 64'h000000FF);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
